// File: rtl/burst_slave_mem_pkg.sv
// Shared definitions for the burst slave memory.
// Holds the bus widths, the default depth and the controller state encoding.
package burst_slave_mem_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_READ    = 2'd3
  } state_e;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator: loadable wrapping word pointer plus a
// beats-remaining counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load ptr_i / rem_i (takes priority over step_i)
//   step_i       : advance pointer (wraps modulo 2^ADDR_W), decrement remaining
//   ptr_o, rem_o : current pointer and beats remaining
//   last_o       : exactly one beat remains
//   done_o       : no beats remain
module burst_addr_gen
  import burst_slave_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] ptr_i,
  input  logic [LEN_W-1:0]  rem_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic [LEN_W-1:0]  rem_o,
  output logic              last_o,
  output logic              done_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (load_i) begin
      ptr_d = ptr_i;
      rem_d = rem_i;
    end else if (step_i) begin
      ptr_d = ptr_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign rem_o  = rem_q;
  assign last_o = (rem_q == LEN_W'(1));
  assign done_o = (rem_q == '0);

endmodule

// File: rtl/burst_slave_mem.sv
// Burst slave memory: 32-bit word array with single-command write and read
// bursts, wrapping word addresses and a fixed read latency.
//   clock, reset        : clock, synchronous active-high reset
//   io_slv_wr / _rd     : one-cycle burst commands (write wins if both)
//   io_slv_address      : burst start word address
//   io_slv_length       : beat count, 0 is rejected
//   io_slv_wdata        : write beat data, one beat per cycle
//   io_slv_ready        : command / write beat accepted this cycle
//   io_slv_rdata        : registered read beat, held while not valid
//   io_slv_rddatavalid  : io_slv_rdata holds a beat
//   io_slv_drop         : one-cycle pulse, a command was discarded
module burst_slave_mem
  import burst_slave_mem_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned DEPTH      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_slv_wr,
  input  logic        io_slv_rd,
  input  logic [3:0]  io_slv_address,
  input  logic [3:0]  io_slv_length,
  input  logic [31:0] io_slv_wdata,
  output logic        io_slv_ready,
  output logic [31:0] io_slv_rdata,
  output logic        io_slv_rddatavalid,
  output logic        io_slv_drop
);

  // rdata is registered, so the READ state must start one cycle before the
  // first valid beat: RD_WAIT lasts RD_LATENCY-1 cycles, a latency of 1
  // skips it, and a latency of 0 reads the first beat in the command cycle.
  localparam logic [2:0] WAIT_INIT = (RD_LATENCY >= 2) ? 3'(RD_LATENCY - 2) : '0;

  state_e            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdv_q, rdv_d;
  logic              drop_q, drop_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;

  logic              ag_load, ag_step, ag_last, ag_done;
  logic [ADDR_W-1:0] ag_ptr_in, ag_ptr;
  logic [LEN_W-1:0]  ag_rem_in, ag_rem;

  burst_addr_gen u_addr_gen (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (ag_load),
    .ptr_i  (ag_ptr_in),
    .rem_i  (ag_rem_in),
    .step_i (ag_step),
    .ptr_o  (ag_ptr),
    .rem_o  (ag_rem),
    .last_o (ag_last),
    .done_o (ag_done)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    rdv_d     = 1'b0;
    drop_d    = 1'b0;
    ag_load   = 1'b0;
    ag_step   = 1'b0;
    ag_ptr_in = io_slv_address;
    ag_rem_in = io_slv_length;
    mem_we    = 1'b0;
    mem_waddr = ag_ptr;
    case (state_q)
      S_IDLE: begin
        if (io_slv_wr) begin
          drop_d = io_slv_rd || (io_slv_length == '0);
          if (io_slv_length != '0) begin
            mem_we    = 1'b1;
            mem_waddr = io_slv_address;
            ag_load   = 1'b1;
            ag_ptr_in = io_slv_address + 1'b1;
            ag_rem_in = io_slv_length - 1'b1;
            if (io_slv_length != LEN_W'(1)) state_d = S_WRITE;
          end
        end else if (io_slv_rd) begin
          if (io_slv_length == '0) begin
            drop_d = 1'b1;
          end else if (RD_LATENCY == 0) begin
            rdata_d   = mem[io_slv_address];
            rdv_d     = 1'b1;
            ag_load   = 1'b1;
            ag_ptr_in = io_slv_address + 1'b1;
            ag_rem_in = io_slv_length - 1'b1;
            if (io_slv_length != LEN_W'(1)) state_d = S_READ;
          end else begin
            ag_load = 1'b1;
            wait_d  = WAIT_INIT;
            state_d = (RD_LATENCY == 1) ? S_READ : S_RD_WAIT;
          end
        end
      end
      S_WRITE: begin
        drop_d = io_slv_wr || io_slv_rd;
        if (!ag_done) begin
          mem_we  = 1'b1;
          ag_step = 1'b1;
        end
        if (ag_last || ag_done) state_d = S_IDLE;
      end
      S_RD_WAIT: begin
        drop_d = io_slv_wr || io_slv_rd;
        if (wait_q == '0) state_d = S_READ;
        else              wait_d  = wait_q - 1'b1;
      end
      S_READ: begin
        drop_d = io_slv_wr || io_slv_rd;
        if (!ag_done) begin
          rdata_d = mem[ag_ptr];
          rdv_d   = 1'b1;
          ag_step = 1'b1;
        end
        if (ag_last || ag_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is never reset; a reset cycle only suppresses the write.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[mem_waddr] <= io_slv_wdata;
  end

  assign io_slv_ready       = (state_q == S_IDLE) || (state_q == S_WRITE);
  assign io_slv_rdata       = rdata_q;
  assign io_slv_rddatavalid = rdv_q;
  assign io_slv_drop        = drop_q;

endmodule

// File: tb/tb_burst_slave_mem.sv
module tb_burst_slave_mem;

  localparam int L = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_slv_wr, io_slv_rd;
  logic [3:0]  io_slv_address, io_slv_length;
  logic [31:0] io_slv_wdata;
  logic        io_slv_ready;
  logic [31:0] io_slv_rdata;
  logic        io_slv_rddatavalid;
  logic        io_slv_drop;

  burst_slave_mem #(.RD_LATENCY(L), .DEPTH(16)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_slv_wr          (io_slv_wr),
    .io_slv_rd          (io_slv_rd),
    .io_slv_address     (io_slv_address),
    .io_slv_length      (io_slv_length),
    .io_slv_wdata       (io_slv_wdata),
    .io_slv_ready       (io_slv_ready),
    .io_slv_rdata       (io_slv_rdata),
    .io_slv_rddatavalid (io_slv_rddatavalid),
    .io_slv_drop        (io_slv_drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    cyc_cnt = 0;
  int    checks  = 0;
  int    fails   = 0;
  int    drops_seen = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: every valid read beat is matched against the scoreboard queue.
  always @(negedge clock) begin
    if (io_slv_drop === 1'b1) drops_seen++;
    if (io_slv_rddatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_beat: got %h expected no beat (cycle %0d)", io_slv_rdata, cyc_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata", io_slv_rdata, mon_e.data);
        check("beat_cycle", 32'(cyc_cnt), 32'(mon_e.cyc));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      io_slv_wr = 1'b0;
      io_slv_rd = 1'b0;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] l, input logic [31:0] d [4]);
    for (int i = 0; i < int'(l); i++) begin
      cyc();
      io_slv_wr      = (i == 0);
      io_slv_rd      = 1'b0;
      io_slv_address = a;
      io_slv_length  = l;
      io_slv_wdata   = d[i];
      @(negedge clock);
      check("ready_during_write", {31'b0, io_slv_ready}, 32'd1);
    end
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] l, input logic [31:0] d [4],
                         input int npush);
    beat_t b;
    cyc();
    io_slv_wr      = 1'b0;
    io_slv_rd      = 1'b1;
    io_slv_address = a;
    io_slv_length  = l;
    for (int i = 0; i < npush; i++) begin
      b.data = d[i];
      b.cyc  = cyc_cnt + L + 1 + i;
      exp_q.push_back(b);
    end
  endtask

  int d0;
  int n;

  initial begin
    reset = 1'b1;
    io_slv_wr = 1'b0; io_slv_rd = 1'b0;
    io_slv_address = '0; io_slv_length = '0; io_slv_wdata = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_ready", {31'b0, io_slv_ready}, 32'd1);
    check("reset_rdv",   {31'b0, io_slv_rddatavalid}, 32'd0);
    check("reset_rdata", io_slv_rdata, 32'd0);
    check("reset_drop",  {31'b0, io_slv_drop}, 32'd0);

    // Write 6..9 then read back with latency check.
    d0 = drops_seen;
    do_write(4'd6, 4'd4, '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004});
    idle(1);
    do_read(4'd6, 4'd4, '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004}, 4);
    idle(8);
    check("no_drop_basic", 32'(drops_seen - d0), 32'd0);

    // Wrapping burst E,F,0,1.
    do_write(4'hE, 4'd4, '{32'd1, 32'd2, 32'd3, 32'd4});
    idle(1);
    do_read(4'hE, 4'd4, '{32'd1, 32'd2, 32'd3, 32'd4}, 4);
    idle(8);
    do_read(4'h0, 4'd2, '{32'd3, 32'd4, 32'd0, 32'd0}, 2);
    idle(6);

    // rd during READ, then wr+rd together in IDLE.
    d0 = drops_seen;
    do_read(4'd6, 4'd4, '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004}, 4);
    idle(2);
    cyc();
    io_slv_rd = 1'b1; io_slv_address = 4'd0; io_slv_length = 4'd2;
    idle(6);
    cyc();
    io_slv_wr = 1'b1; io_slv_rd = 1'b1; io_slv_address = 4'd3; io_slv_length = 4'd1;
    io_slv_wdata = 32'h5555_5555;
    idle(3);
    check("drop_count_busy_and_both", 32'(drops_seen - d0), 32'd2);
    do_read(4'd3, 4'd1, '{32'h5555_5555, 32'd0, 32'd0, 32'd0}, 1);
    idle(5);

    // Zero-length write is dropped and leaves memory alone.
    d0 = drops_seen;
    cyc();
    io_slv_wr = 1'b1; io_slv_address = 4'd6; io_slv_length = 4'd0; io_slv_wdata = 32'hDEAD_BEEF;
    cyc();
    io_slv_wr = 1'b0;
    @(negedge clock);
    check("len0_drop_pulse", {31'b0, io_slv_drop}, 32'd1);
    check("len0_ready", {31'b0, io_slv_ready}, 32'd1);
    idle(2);
    check("len0_drop_count", 32'(drops_seen - d0), 32'd1);
    do_read(4'd6, 4'd1, '{32'hAAAA_0001, 32'd0, 32'd0, 32'd0}, 1);
    idle(5);

    // Reset on the second read beat.
    do_read(4'd6, 4'd4, '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004}, 2);
    n = cyc_cnt;
    idle(3);
    cyc();
    io_slv_rd = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_cycle", 32'(cyc_cnt), 32'(n + 5));
    check("rst_mid_rdv",   {31'b0, io_slv_rddatavalid}, 32'd0);
    check("rst_mid_rdata", io_slv_rdata, 32'd0);
    check("rst_mid_ready", {31'b0, io_slv_ready}, 32'd1);
    do_write(4'd6, 4'd1, '{32'h7777_7777, 32'd0, 32'd0, 32'd0});
    idle(1);
    do_read(4'd6, 4'd2, '{32'h7777_7777, 32'hBBBB_0002, 32'd0, 32'd0}, 2);
    idle(7);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_beats: got %0d outstanding expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
